// File: rtl/mskand_hpc2_vec_pipe_if.sv
// Valid/ready bundle for the masked AND pipeline: operand sharings, randomness stream, result.
// Share j of bit k sits at index k*D+j; pair randomness of bit k sits at rnd[k*R +: R].
interface mskand_hpc2_vec_pipe_if #(
    parameter int unsigned D = 2,
    parameter int unsigned N = 8
);
    localparam int unsigned R = D * (D - 1) / 2;
    localparam int unsigned W = N * D;

    logic           in_valid;
    logic           in_ready;
    logic [W-1:0]   ina;
    logic [W-1:0]   inb;
    logic           rnd_valid;
    logic           rnd_ready;
    logic [N*R-1:0] rnd;
    logic           out_valid;
    logic           out_ready;
    logic [W-1:0]   out;

    modport master (
        output in_valid, ina, inb, rnd_valid, rnd, out_ready,
        input  in_ready, rnd_ready, out_valid, out
    );

    modport slave (
        input  in_valid, ina, inb, rnd_valid, rnd, out_ready,
        output in_ready, rnd_ready, out_valid, out
    );
endinterface

// File: rtl/mskand_hpc2_vec_pipe.sv
// N-bit vector of d-share HPC2 masked AND gates in a two-stage valid/ready pipeline.
// Operands and randomness are consumed together; the pipeline freezes while the output is stalled.
module mskand_hpc2_vec_pipe #(
    parameter int unsigned D = 2,
    parameter int unsigned N = 8
) (
    input  logic                  clk,
    input  logic                  rst,
    mskand_hpc2_vec_pipe_if.slave bus
);
    localparam int unsigned R  = D * (D - 1) / 2;
    localparam int unsigned P  = D * (D - 1);
    localparam int unsigned W  = N * D;
    localparam int unsigned WP = N * P;

    // Position of unordered pair (lo,hi), lo<hi, in the order (0,1),(0,2)..(D-2,D-1).
    function automatic int unsigned f_upair(input int unsigned lo, input int unsigned hi);
        int unsigned idx;
        idx = 0;
        for (int unsigned a = 0; a < lo; a++) idx += D - 1 - a;
        return idx + hi - lo - 1;
    endfunction

    // Ordered pair (i,j), j!=i; terms belonging to share i are contiguous.
    function automatic int unsigned f_opair(input int unsigned i, input int unsigned j);
        return i * (D - 1) + ((j < i) ? j : j - 1);
    endfunction

    logic          w_en;
    logic          w_accept;
    logic          r_v1;
    logic          r_v2;
    logic [W-1:0]  r_a1;
    logic [W-1:0]  r_b1;
    logic [WP-1:0] r_m;
    logic [WP-1:0] r_q;
    logic [W-1:0]  r_p;
    logic [WP-1:0] r_x;
    logic [WP-1:0] r_y;
    logic [WP-1:0] w_m_d;
    logic [WP-1:0] w_q_d;
    logic [W-1:0]  w_p_d;
    logic [WP-1:0] w_x_d;
    logic [WP-1:0] w_y_d;
    logic [W-1:0]  w_out;

    assign w_en          = ~r_v2 | bus.out_ready;
    assign w_accept      = bus.in_valid & bus.rnd_valid & w_en;
    assign bus.in_ready  = bus.rnd_valid & w_en;
    assign bus.rnd_ready = bus.in_valid & w_en;
    assign bus.out_valid = r_v2;
    assign bus.out       = w_out;

    for (genvar k = 0; k < N; k++) begin : g_bit
        for (genvar i = 0; i < D; i++) begin : g_share
            localparam int unsigned SI   = k * D + i;
            localparam int unsigned BASE = k * P + i * (D - 1);

            assign w_p_d[SI] = r_a1[SI] & r_b1[SI];

            for (genvar j = 0; j < D; j++) begin : g_pair
                if (j != i) begin : g_cross
                    localparam int unsigned OIJ = k * P + f_opair(i, j);
                    localparam int unsigned RIJ = k * R + ((i < j) ? f_upair(i, j) : f_upair(j, i));

                    // Blinded operand and its mask are kept in separate registers.
                    assign w_m_d[OIJ] = bus.inb[k * D + j] ^ bus.rnd[RIJ];
                    assign w_q_d[OIJ] = bus.rnd[RIJ];
                    assign w_x_d[OIJ] = r_a1[SI] & r_m[OIJ];
                    assign w_y_d[OIJ] = ~r_a1[SI] & r_q[OIJ];
                end
            end

            // Only place shares meet: XOR of registered stage-2 terms.
            assign w_out[SI] = r_p[SI] ^ (^(r_x[BASE +: D - 1] ^ r_y[BASE +: D - 1]));
        end
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_v1 <= 1'b0;
            r_v2 <= 1'b0;
            r_a1 <= '0;
            r_b1 <= '0;
            r_m  <= '0;
            r_q  <= '0;
            r_p  <= '0;
            r_x  <= '0;
            r_y  <= '0;
        end else if (w_en) begin
            r_v1 <= w_accept;
            r_a1 <= bus.ina;
            r_b1 <= bus.inb;
            r_m  <= w_m_d;
            r_q  <= w_q_d;
            r_v2 <= r_v1;
            r_p  <= w_p_d;
            r_x  <= w_x_d;
            r_y  <= w_y_d;
        end
    end
endmodule
